// File: rtl/pkt_attr_pkg.sv
// Shared constants for the packet attribute word: field positions, ethertypes,
// IP protocol numbers and the header-buffer byte accessor.
package pkt_attr_pkg;

    localparam int DATA_W  = 256;
    localparam int TUSER_W = 128;
    localparam int ATTR_W  = 135;
    localparam int NUM_Q   = 8;
    localparam int TUPLE_W = 104;
    localparam int LEN_W   = 16;

    localparam int TUSER_SRC_LSB = 16;
    localparam int HDR_BITS      = 3 * DATA_W;

    localparam int ATTR_SRC_LSB = 127;
    localparam int FLAG_VLAN_AD = 124;
    localparam int FLAG_VLAN_Q  = 123;
    localparam int FLAG_UDP     = 122;
    localparam int FLAG_TCP     = 121;
    localparam int FLAG_IP      = 120;
    localparam int ATTR_LEN_LSB = 104;

    localparam int TUPLE_SRC_IP_LSB   = 72;
    localparam int TUPLE_DST_IP_LSB   = 40;
    localparam int TUPLE_PROTO_LSB    = 32;
    localparam int TUPLE_SRC_PORT_LSB = 16;
    localparam int TUPLE_DST_PORT_LSB = 0;

    localparam logic [15:0] ETH_IPV4    = 16'h0800;
    localparam logic [15:0] ETH_VLAN_Q  = 16'h8100;
    localparam logic [15:0] ETH_VLAN_AD = 16'h88A8;
    localparam logic [7:0]  PROTO_TCP   = 8'd6;
    localparam logic [7:0]  PROTO_UDP   = 8'd17;

    typedef enum logic [1:0] {
        ST_FIRST    = 2'd0,
        ST_HDR      = 2'd1,
        ST_WAIT_EOP = 2'd2
    } state_e;

    function automatic logic [7:0] hdr_byte(input logic [HDR_BITS-1:0] hdr, input logic [6:0] idx);
        return hdr[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/hdr_field_parse.sv
// Combinational parse of the 96-byte header buffer into VLAN/IP/L4 flags and
// the IPv4 5-tuple.
module hdr_field_parse
    import pkt_attr_pkg::*;
(
    input  logic [HDR_BITS-1:0] hdr_i,
    output logic                ip_o,
    output logic                tcp_o,
    output logic                udp_o,
    output logic                vlan_q_o,
    output logic                vlan_ad_o,
    output logic [TUPLE_W-1:0]  tuple_o
);

    logic [15:0] outer_et;
    logic [15:0] inner_et;
    logic [6:0]  vlan_off;
    logic [6:0]  l3_off;
    logic [6:0]  l4_off;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic        frag_zero;

    always_comb begin
        vlan_ad_o = 1'b0;
        vlan_q_o  = 1'b0;
        vlan_off  = 7'd0;
        outer_et  = {hdr_byte(hdr_i, 7'd12), hdr_byte(hdr_i, 7'd13)};
        // An inner C-tag under an S-tag is skipped but not reported as VLAN_Q
        if (outer_et == ETH_VLAN_AD) begin
            vlan_ad_o = 1'b1;
            vlan_off  = 7'd4;
            if ({hdr_byte(hdr_i, 7'd16), hdr_byte(hdr_i, 7'd17)} == ETH_VLAN_Q) begin
                vlan_off = 7'd8;
            end
        end else if (outer_et == ETH_VLAN_Q) begin
            vlan_q_o = 1'b1;
            vlan_off = 7'd4;
        end

        l3_off    = 7'd14 + vlan_off;
        inner_et  = {hdr_byte(hdr_i, l3_off - 7'd2), hdr_byte(hdr_i, l3_off - 7'd1)};
        ver_ihl   = hdr_byte(hdr_i, l3_off);
        proto     = hdr_byte(hdr_i, l3_off + 7'd9);
        frag_zero = (({hdr_byte(hdr_i, l3_off + 7'd6), hdr_byte(hdr_i, l3_off + 7'd7)}
                      & 16'h1FFF) == 16'h0000);
        l4_off    = l3_off + {1'b0, ver_ihl[3:0], 2'b00};

        ip_o  = (inner_et == ETH_IPV4) && (ver_ihl[7:4] == 4'd4) && (ver_ihl[3:0] >= 4'd5);
        tcp_o = ip_o && (proto == PROTO_TCP) && frag_zero;
        udp_o = ip_o && (proto == PROTO_UDP) && frag_zero;

        tuple_o = '0;
        if (ip_o) begin
            tuple_o[TUPLE_SRC_IP_LSB +: 32] = {hdr_byte(hdr_i, l3_off + 7'd12), hdr_byte(hdr_i, l3_off + 7'd13),
                                               hdr_byte(hdr_i, l3_off + 7'd14), hdr_byte(hdr_i, l3_off + 7'd15)};
            tuple_o[TUPLE_DST_IP_LSB +: 32] = {hdr_byte(hdr_i, l3_off + 7'd16), hdr_byte(hdr_i, l3_off + 7'd17),
                                               hdr_byte(hdr_i, l3_off + 7'd18), hdr_byte(hdr_i, l3_off + 7'd19)};
            tuple_o[TUPLE_PROTO_LSB +: 8]   = proto;
            if (tcp_o || udp_o) begin
                tuple_o[TUPLE_SRC_PORT_LSB +: 16] = {hdr_byte(hdr_i, l4_off), hdr_byte(hdr_i, l4_off + 7'd1)};
                tuple_o[TUPLE_DST_PORT_LSB +: 16] = {hdr_byte(hdr_i, l4_off + 7'd2), hdr_byte(hdr_i, l4_off + 7'd3)};
            end
        end
    end

endmodule

// File: rtl/pkt_attr_extractor.sv
// Passive AXI4-Stream snooper: buffers the first three beats of each packet and
// emits one registered attribute word, strobed the cycle after tlast.
//   state       | meaning
//   ST_FIRST    | next accepted beat starts a packet (latch tuser, fill hdr[0])
//   ST_HDR      | filling hdr[1] then hdr[2]
//   ST_WAIT_EOP | header captured, ignoring beats until tlast
module pkt_attr_extractor
    import pkt_attr_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W,
    parameter int ATTRIBUTE_DATA_WIDTH = ATTR_W,
    parameter int NUM_INPUT_QUEUES     = NUM_Q,
    parameter int TUPLE_WIDTH          = TUPLE_W,
    parameter int BYTES_COUNT_WIDTH    = LEN_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [ATTRIBUTE_DATA_WIDTH-1:0]   pkt_attributes,
    output logic                              pkt_valid
);

    state_e                            state_q, state_d;
    logic                              beat_sel_q, beat_sel_d;
    logic [HDR_BITS-1:0]               hdr_q, hdr_d;
    logic [BYTES_COUNT_WIDTH-1:0]      len_q, len_cur;
    logic [NUM_INPUT_QUEUES-1:0]       src_q, src_cur;
    logic [ATTRIBUTE_DATA_WIDTH-1:0]   attr_q, attr_d;
    logic                              valid_q;
    logic [DATA_W-1:0]                 beat_data;
    logic                              accept;
    logic                              eop;
    logic                              ip, tcp, udp, vlan_q, vlan_ad;
    logic [TUPLE_WIDTH-1:0]            tuple;
    logic                              unused_tuser;

    assign accept       = s_axis_tvalid && s_axis_tready;
    assign eop          = accept && s_axis_tlast;
    assign unused_tuser = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TUSER_SRC_LSB+NUM_INPUT_QUEUES];

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < DATA_W / 8; k++) begin
            beat_data[8*k +: 8] = s_axis_tkeep[k] ? s_axis_tdata[8*k +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FIRST;
            beat_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_sel_q <= beat_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_sel_d = beat_sel_q;
        if (accept) begin
            if (s_axis_tlast) begin
                state_d    = ST_FIRST;
                beat_sel_d = 1'b0;
            end else begin
                case (state_q)
                    ST_FIRST: begin
                        state_d    = ST_HDR;
                        beat_sel_d = 1'b0;
                    end
                    ST_HDR: begin
                        if (beat_sel_q) state_d = ST_WAIT_EOP;
                        else            beat_sel_d = 1'b1;
                    end
                    ST_WAIT_EOP: state_d = ST_WAIT_EOP;
                    default: begin
                        state_d    = ST_FIRST;
                        beat_sel_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // hdr_d is the buffer as it would look with the current beat merged in;
    // the parser reads it so the tlast beat itself contributes to the result.
    always_comb begin
        hdr_d = hdr_q;
        case (state_q)
            ST_FIRST: hdr_d = {{(HDR_BITS-DATA_W){1'b0}}, beat_data};
            ST_HDR: begin
                if (beat_sel_q) hdr_d[2*DATA_W +: DATA_W] = beat_data;
                else            hdr_d[DATA_W +: DATA_W]   = beat_data;
            end
            default: hdr_d = hdr_q;
        endcase
    end

    assign len_cur = (state_q == ST_FIRST) ? s_axis_tuser[BYTES_COUNT_WIDTH-1:0] : len_q;
    assign src_cur = (state_q == ST_FIRST) ? s_axis_tuser[TUSER_SRC_LSB +: NUM_INPUT_QUEUES] : src_q;

    hdr_field_parse u_parse (
        .hdr_i     (hdr_d),
        .ip_o      (ip),
        .tcp_o     (tcp),
        .udp_o     (udp),
        .vlan_q_o  (vlan_q),
        .vlan_ad_o (vlan_ad),
        .tuple_o   (tuple)
    );

    always_comb begin
        attr_d                                       = '0;
        attr_d[ATTR_SRC_LSB +: NUM_INPUT_QUEUES]     = src_cur;
        attr_d[FLAG_VLAN_AD]                         = vlan_ad;
        attr_d[FLAG_VLAN_Q]                          = vlan_q;
        attr_d[FLAG_UDP]                             = udp;
        attr_d[FLAG_TCP]                             = tcp;
        attr_d[FLAG_IP]                              = ip;
        attr_d[ATTR_LEN_LSB +: BYTES_COUNT_WIDTH]    = len_cur;
        attr_d[TUPLE_WIDTH-1:0]                      = tuple;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            attr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) hdr_q <= hdr_d;
            if (accept && (state_q == ST_FIRST)) begin
                len_q <= len_cur;
                src_q <= src_cur;
            end
            valid_q <= eop;
            if (eop) attr_q <= attr_d;
        end
    end

    assign pkt_attributes = attr_q;
    assign pkt_valid      = valid_q;

endmodule

// File: doc/pkt_attr_extractor.md
Name: pkt_attr_extractor

Overview:
- Passive header parser that snoops the monitor's ingress AXI4-Stream and emits one attribute word per packet.
- Output is `pkt_attributes` plus a 1-cycle `pkt_valid`, consumed directly by the per-port statistics counters.
- Extracts: source port one-hot, byte length, IPv4 5-tuple, and IP/TCP/UDP/VLAN flags.
- Never back-pressures the stream; it observes `tvalid && tready` only.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width; fixed, only 256 supported.
- C_S_AXIS_TUSER_WIDTH, 128, sideband width; [15:0] = packet length in bytes, [23:16] = source port one-hot.
- ATTRIBUTE_DATA_WIDTH, 135, output attribute word width.
- NUM_INPUT_QUEUES, 8, width of source one-hot.
- TUPLE_WIDTH, 104, 5-tuple field width.
- BYTES_COUNT_WIDTH, 16, length field width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_axis_tdata  in  256  packet data; byte k at [8k+7:8k]; multibyte fields network order
- s_axis_tkeep  in  32  byte enables (last beat only partial)
- s_axis_tuser  in  128  sideband, valid on first beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  in  1  downstream ready (snooped)
- s_axis_tlast  in  1  last beat
- pkt_attributes  out  135  attribute word
- pkt_valid  out  1  single-cycle strobe qualifying pkt_attributes

Behaviour:
- Beat accepted when `tvalid && tready`. Other cycles are ignored and state holds.
- Attribute layout:
  - [134:127] src one-hot (tuser[23:16] latched on first beat)
  - [126:125] zero
  - [124] VLAN_AD, [123] VLAN_Q, [122] UDP, [121] TCP, [120] IP
  - [119:104] length (tuser[15:0] latched on first beat)
  - [103:0] tuple, packed as:
    - [103:72] IPv4 src
    - [71:40] IPv4 dst
    - [39:32] protocol
    - [31:16] L4 src port
    - [15:0] L4 dst port
- FSM states:
  - FIRST: awaits first beat; latches tuser; stores beat into hdr[0].
  - HDR: stores beats 1 and 2 into hdr[1], hdr[2].
  - WAIT_EOP: ignores further beats.
- Transitions:
  - Any accepted beat with tlast → FIRST.
  - Otherwise FIRST→HDR, HDR→HDR after beat 1, HDR→WAIT_EOP after beat 2.
- Header buffer (96 bytes):
  - Cleared to zero on each first beat (except the beat itself), so bytes past end-of-packet read as 0.
  - Bytes with tkeep=0 are stored as 0.
- Parsing is evaluated on the tlast beat over the buffer merged with the current beat:
  - Ethertype at bytes 12-13.
  - 0x88A8 → VLAN_AD=1, skip 4 bytes; an inner tag 0x8100 is then skipped too (offset 8), but VLAN_Q stays 0.
  - 0x8100 → VLAN_Q=1, offset 4.
  - Inner ethertype 0x0800 with version nibble 4 and IHL≥5 → IP=1.
  - IPv4 fields at L3 offset o = 14+vlan_off: proto byte o+9, src o+12..15, dst o+16..19, frag offset = 13 LSBs of bytes o+6..7.
  - L4 offset = o + 4*IHL.
  - TCP=1 iff IP, proto 6 and frag offset 0; UDP=1 iff IP, proto 17 and frag offset 0. Ports are read from the L4 offset only then, else 0.
  - Non-IP: tuple and IP/TCP/UDP flags all zero; VLAN flags still reported.
- Output timing:
  - `pkt_attributes` and `pkt_valid` registered; `pkt_valid`=1 exactly the cycle after the tlast beat (latency 1), else 0.
  - `pkt_attributes` holds its value until the next strobe.
- Back-to-back packets (tlast followed by a new first beat next cycle) are fully supported, one attribute per packet. A single-beat packet is both first and last beat.
- Reset: FSM→FIRST, buffer cleared, `pkt_valid`=0, `pkt_attributes`=0. A packet in flight at reset is discarded, and parsing resumes at the next accepted beat, which is treated as a first beat.
- Beats with tvalid=1 and tready=0 are not counted.

Decomposition:
- Shared package `pkt_attr_pkg`:
  - Attribute bit positions (FLAG_IP…FLAG_VLAN_AD, length and src offsets), also used by the stats stage.
  - Ethertype constants 0x0800, 0x8100, 0x88A8; protocol constants 6 and 17.
  - Tuple field offsets.
- One sub-module `hdr_field_parse`: combinational parse of the 96-byte buffer into flags and tuple; the FSM and buffer stay in the top module.

Test Plan:
- Untagged IPv4/TCP, 2 beats: tuser={0x01,len 64}, 10.0.0.1→10.0.0.2, ports 1234→80 → one strobe cycle after tlast; attr[134:127]=0x01, [119:104]=64, IP=1, TCP=1, tuple=0x0A000001_0A000002_06_04D2_0050.
- 802.1Q-tagged IPv4/UDP, src port 0x10, len 1514 (48 beats) → VLAN_Q=1, UDP=1, ports correct at 4-byte shift, exactly one strobe.
- QinQ (0x88A8 outer, 0x8100 inner) IPv4 with IHL=15, TCP → VLAN_AD=1, VLAN_Q=0, TCP ports taken from beat 2 (bytes 82-85).
- ARP (0x0806) then IPv4 fragment (offset 185, proto 17), back-to-back with no idle → two strobes on consecutive packets:
  - ARP: all flags 0, tuple 0.
  - Fragment: IP=1, UDP=0, ports 0.
- tready toggling 50% mid-packet → attributes identical to the tready=1 run.
- reset asserted on beat 1 of a packet → no strobe for it; the next packet parses correctly.
